// File: rtl/rv_irq_ctrl.sv
// ---------------------------------------------------------------------------
// rv_irq_ctrl
//
// Interrupt controller for the single-cycle RISC-V core. It synchronises and
// edge-detects the six board request lines, latches each rising edge as a
// pending bit, and offers the highest-priority eligible source to the CPU
// through a req/ack handshake with a vector address. In-service sources are
// tracked until the CPU signals end-of-interrupt.
//
// Optional feature macro: IRQ_CTRL_NESTING_EN
//   defined   : nested interrupts. A pending source may preempt if its
//               priority is strictly higher than every in-service source.
//   undefined : no nesting. A new request is only offered while nothing is
//               in service, so at most one in-service bit is ever set.
//
// Ports:
//   CLK         system clock, all state updates on the rising edge
//   RST         synchronous active-high reset
//   irq         raw asynchronous request lines, rising edge = request
//   irq_en      per-source enable
//   gie         global interrupt enable
//   int_req     interrupt request to the CPU
//   int_vec     vector address of the requested source (valid with int_req)
//   int_id      index of the requested source (valid with int_req)
//   int_ack     CPU accepts the current request (single-cycle pulse)
//   int_eoi     CPU end-of-interrupt (single-cycle pulse)
//   pending     pending register, debug view
//   in_service  in-service register, debug view
//
// Priority: bit 0 (IRA) is highest, bit NUM_SRC-1 (IRF) is lowest.
// ---------------------------------------------------------------------------
module rv_irq_ctrl #(
    parameter int unsigned NUM_SRC    = 6,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] irq,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               gie,
    output logic               int_req,
    output logic [31:0]        int_vec,
    output logic [2:0]         int_id,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service
);

    localparam logic [NUM_SRC-1:0] SRC_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [2:0]         int_id_q, int_id_d;
    logic [31:0]        int_vec_q, int_vec_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] allowMask;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] eoiMask;
    logic [NUM_SRC-1:0] ackMask;
    logic               candValid;
    logic [2:0]         candIdx;
    logic               ackFire;

    // Three-flop chain: s1/s2 resolve metastability, s3 is the previous
    // synchronised value used for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Sources allowed to be offered given what is currently in service.
`ifdef IRQ_CTRL_NESTING_EN
    // A source may preempt only if it sits strictly above the highest-priority
    // (lowest-index) in-service bit; everything at or below it is blocked.
    always_comb begin : preempt_mask
        logic busy;
        busy      = 1'b0;
        allowMask = '0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            busy         = busy | in_service_q[j];
            allowMask[j] = ~busy;
        end
    end
`else
    // Without nesting nothing is offered while any source is in service.
    assign allowMask = {NUM_SRC{(in_service_q == '0)}};
`endif

    assign eligible = pending_q & irq_en & {NUM_SRC{gie}} & allowMask;

    // Fixed-priority encoder, lowest index wins.
    always_comb begin
        candValid = 1'b0;
        candIdx   = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                candValid = 1'b1;
                candIdx   = 3'(i);
            end
        end
    end

    assign ackFire = (state_q == REQ) && int_ack;
    assign ackMask = ackFire ? (SRC_ONE << int_id_q) : '0;

    // x & -x isolates the lowest set bit, i.e. the highest-priority
    // in-service source; an empty register yields zero so eoi is a no-op.
    assign eoiMask = int_eoi ? (in_service_q & (~in_service_q + SRC_ONE)) : '0;

    // The rise is ORed in after the ack clear so a new edge landing in the
    // ack cycle is not lost. The eoi clear uses the old in_service before
    // the ack sets its bit.
    assign pending_d    = (pending_q & ~ackMask) | rise;
    assign in_service_d = (in_service_q & ~eoiMask) | ackMask;

    // State register plus the request id/vector captured on entry to REQ.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            int_id_q     <= '0;
            int_vec_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            int_id_q     <= int_id_d;
            int_vec_q    <= int_vec_d;
        end
    end

    // Next-state logic. Once in REQ the id and vector stay frozen until the
    // CPU acks, even if a better source shows up or the enables drop. HOLD
    // gives in_service one cycle to settle before arbitrating again.
    always_comb begin
        state_d   = state_q;
        int_id_d  = int_id_q;
        int_vec_d = int_vec_q;
        case (state_q)
            IDLE: begin
                if (candValid) begin
                    state_d   = REQ;
                    int_id_d  = candIdx;
                    int_vec_d = VEC_BASE + 32'(candIdx) * VEC_STRIDE;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        int_req    = (state_q == REQ);
        int_id     = int_id_q;
        int_vec    = int_vec_q;
        pending    = pending_q;
        in_service = in_service_q;
    end

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_irq_ctrl
//
// Directed scenarios with fixed expected values, followed by a randomized
// phase compared cycle-by-cycle against a behavioural model of the
// controller's request/pending/in-service rules.
// ---------------------------------------------------------------------------
module tb_rv_irq_ctrl;

    localparam int N = 6;

    logic         CLK     = 1'b0;
    logic         RST     = 1'b0;
    logic [N-1:0] irq     = '0;
    logic [N-1:0] irq_en  = '1;
    logic         gie     = 1'b1;
    logic         int_ack = 1'b0;
    logic         int_eoi = 1'b0;
    logic         int_req;
    logic [31:0]  int_vec;
    logic [2:0]   int_id;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;

    int errors = 0;
    int checks = 0;

    rv_irq_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .irq        (irq),
        .irq_en     (irq_en),
        .gie        (gie),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_id     (int_id),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 CLK = ~CLK;

    // Behavioural reference: a history of the last three irq samples, the
    // pending and in-service sets, and whether a request is outstanding.
    logic [N-1:0] mHist [0:2] = '{default: '0};
    logic [N-1:0] mPending    = '0;
    logic [N-1:0] mInService  = '0;
    bit           mReq        = 1'b0;
    bit           mHold       = 1'b0;
    int           mId         = 0;

    always @(posedge CLK) begin : refModel
        logic [N-1:0] rise;
        logic [N-1:0] nPend;
        logic [N-1:0] nIs;
        int           lowestBusy;
        int           cand;
        bit           allowed;
        if (RST) begin
            mHist[0]   <= '0;
            mHist[1]   <= '0;
            mHist[2]   <= '0;
            mPending   <= '0;
            mInService <= '0;
            mReq       <= 1'b0;
            mHold      <= 1'b0;
            mId        <= 0;
        end else begin
            rise  = mHist[1] & ~mHist[2];
            nPend = mPending;
            nIs   = mInService;
            lowestBusy = N;
            for (int i = N - 1; i >= 0; i--)
                if (mInService[i]) lowestBusy = i;
            if (int_eoi && lowestBusy < N)
                nIs[lowestBusy] = 1'b0;
            if (mReq) begin
                if (int_ack) begin
                    nPend[mId] = 1'b0;
                    nIs[mId]   = 1'b1;
                    mReq  <= 1'b0;
                    mHold <= 1'b1;
                end
            end else if (mHold) begin
                mHold <= 1'b0;
            end else begin
                cand = -1;
                for (int i = 0; i < N; i++) begin
`ifdef IRQ_CTRL_NESTING_EN
                    allowed = (i < lowestBusy);
`else
                    allowed = (mInService == '0);
`endif
                    if (cand < 0 && mPending[i] && irq_en[i] && gie && allowed)
                        cand = i;
                end
                if (cand >= 0) begin
                    mReq <= 1'b1;
                    mId  <= cand;
                end
            end
            mPending   <= nPend | rise;
            mInService <= nIs;
            mHist[2]   <= mHist[1];
            mHist[1]   <= mHist[0];
            mHist[0]   <= irq;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        irq = '1;
        tick();
        RST = 1'b0;
        irq = '0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b want=0", int_req); end
        checks++; if (pending !== 6'b0) begin errors++; $display("[TB] FAIL reset_pending got=%b want=000000", pending); end
        checks++; if (in_service !== 6'b0) begin errors++; $display("[TB] FAIL reset_inservice got=%b want=000000", in_service); end
        checks++; if (int_vec !== 32'h0) begin errors++; $display("[TB] FAIL reset_vec got=%h want=00000000", int_vec); end
        checks++; if (int_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_id got=%0d want=0", int_id); end
    endtask

    task automatic test_single();
        irq = 6'b000100;
        tick();
        irq = '0;
        tick();
        tick();
        checks++; if (pending !== 6'b000100) begin errors++; $display("[TB] FAIL single_pending got=%b want=000100", pending); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL single_early_req got=%b want=0", int_req); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL single_req got=%b want=1", int_req); end
        checks++; if (int_id !== 3'd2) begin errors++; $display("[TB] FAIL single_id got=%0d want=2", int_id); end
        checks++; if (int_vec !== 32'h108) begin errors++; $display("[TB] FAIL single_vec got=%h want=00000108", int_vec); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (pending !== 6'b0) begin errors++; $display("[TB] FAIL single_ack_pending got=%b want=000000", pending); end
        checks++; if (in_service !== 6'b000100) begin errors++; $display("[TB] FAIL single_ack_is got=%b want=000100", in_service); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL single_ack_req got=%b want=0", int_req); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0) begin errors++; $display("[TB] FAIL single_eoi_is got=%b want=000000", in_service); end
    endtask

    task automatic test_priority();
        irq = 6'b010010;
        tick();
        irq = '0;
        tick();
        tick();
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_req got=%b want=1", int_req); end
        checks++; if (int_id !== 3'd1) begin errors++; $display("[TB] FAIL prio_id got=%0d want=1", int_id); end
        checks++; if (int_vec !== 32'h104) begin errors++; $display("[TB] FAIL prio_vec got=%h want=00000104", int_vec); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (pending !== 6'b010000) begin errors++; $display("[TB] FAIL prio_pending got=%b want=010000", pending); end
        checks++; if (in_service !== 6'b000010) begin errors++; $display("[TB] FAIL prio_is got=%b want=000010", in_service); end
        tick();
        tick();
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_no_preempt got=%b want=0", int_req); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0) begin errors++; $display("[TB] FAIL prio_eoi_is got=%b want=000000", in_service); end
        tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL prio_second_req got=%b want=1", int_req); end
        checks++; if (int_id !== 3'd4) begin errors++; $display("[TB] FAIL prio_second_id got=%0d want=4", int_id); end
        checks++; if (int_vec !== 32'h110) begin errors++; $display("[TB] FAIL prio_second_vec got=%h want=00000110", int_vec); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0 || pending !== 6'b0) begin errors++; $display("[TB] FAIL prio_cleanup got=%b/%b want=000000/000000", in_service, pending); end
    endtask

    task automatic test_preempt();
        irq = 6'b001000;
        tick();
        irq = '0;
        tick();
        tick();
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 3'd3) begin errors++; $display("[TB] FAIL preempt_first got=%b/%0d want=1/3", int_req, int_id); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq = 6'b000001;
        tick();
        irq = '0;
        tick();
        tick();
        tick();
        checks++; if (in_service !== 6'b001000) begin errors++; $display("[TB] FAIL preempt_is got=%b want=001000", in_service); end
`ifdef IRQ_CTRL_NESTING_EN
        checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL preempt_req got=%b want=1", int_req); end
        checks++; if (int_id !== 3'd0 || int_vec !== 32'h100) begin errors++; $display("[TB] FAIL preempt_id got=%0d/%h want=0/00000100", int_id, int_vec); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (in_service !== 6'b001001) begin errors++; $display("[TB] FAIL preempt_nested_is got=%b want=001001", in_service); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b001000) begin errors++; $display("[TB] FAIL preempt_eoi1 got=%b want=001000", in_service); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0) begin errors++; $display("[TB] FAIL preempt_eoi2 got=%b want=000000", in_service); end
`else
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL preempt_blocked got=%b want=0", int_req); end
        checks++; if (pending !== 6'b000001) begin errors++; $display("[TB] FAIL preempt_pending got=%b want=000001", pending); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0 || int_req !== 1'b0) begin errors++; $display("[TB] FAIL preempt_eoi got=%b/%b want=000000/0", in_service, int_req); end
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 3'd0) begin errors++; $display("[TB] FAIL preempt_late_req got=%b/%0d want=1/0", int_req, int_id); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (in_service !== 6'b000001) begin errors++; $display("[TB] FAIL preempt_late_is got=%b want=000001", in_service); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0) begin errors++; $display("[TB] FAIL preempt_late_eoi got=%b want=000000", in_service); end
`endif
    endtask

    task automatic test_mask_hold();
        irq_en = 6'b011111;
        irq    = 6'b100000;
        tick();
        irq = '0;
        repeat (4) tick();
        checks++; if (pending !== 6'b100000) begin errors++; $display("[TB] FAIL mask_pending got=%b want=100000", pending); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL mask_req got=%b want=0", int_req); end
        irq_en = '1;
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 3'd5) begin errors++; $display("[TB] FAIL mask_enable_req got=%b/%0d want=1/5", int_req, int_id); end
        checks++; if (int_vec !== 32'h114) begin errors++; $display("[TB] FAIL mask_vec got=%h want=00000114", int_vec); end
        gie = 1'b0;
        tick();
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 3'd5) begin errors++; $display("[TB] FAIL hold_req got=%b/%0d want=1/5", int_req, int_id); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        gie = 1'b1;
        checks++; if (in_service !== 6'b100000 || pending !== 6'b0) begin errors++; $display("[TB] FAIL hold_ack got=%b/%b want=100000/000000", in_service, pending); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        checks++; if (in_service !== 6'b0) begin errors++; $display("[TB] FAIL hold_eoi got=%b want=000000", in_service); end
    endtask

    task automatic test_collision_reset();
        irq = 6'b000100;
        tick();
        irq = '0;
        tick();
        tick();
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 3'd2) begin errors++; $display("[TB] FAIL coll_req got=%b/%0d want=1/2", int_req, int_id); end
        irq = 6'b000100;
        tick();
        irq = '0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++; if (pending !== 6'b000100) begin errors++; $display("[TB] FAIL coll_pending got=%b want=000100", pending); end
        checks++; if (in_service !== 6'b000100) begin errors++; $display("[TB] FAIL coll_is got=%b want=000100", in_service); end
        tick();
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL coll_self_block got=%b want=0", int_req); end
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 3'd2) begin errors++; $display("[TB] FAIL coll_rereq got=%b/%0d want=1/2", int_req, int_id); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL req_reset got=%b want=0", int_req); end
        checks++; if (pending !== 6'b0 || in_service !== 6'b0) begin errors++; $display("[TB] FAIL req_reset_regs got=%b/%b want=000000/000000", pending, in_service); end
        checks++; if (int_vec !== 32'h0 || int_id !== 3'd0) begin errors++; $display("[TB] FAIL req_reset_vec got=%h/%0d want=00000000/0", int_vec, int_id); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            irq = N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en = N'($urandom) | N'($urandom);
            gie     = ($urandom_range(0, 9) != 0);
            int_ack = mReq ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            int_eoi = ($urandom_range(0, 7) == 0);
            RST     = ($urandom_range(0, 499) == 0);
            tick();
            checks++; if (int_req !== mReq) begin errors++; $display("[TB] FAIL rand_req cycle=%0d got=%b want=%b", c, int_req, mReq); end
            if (mReq) begin
                checks++; if (int_id !== 3'(mId)) begin errors++; $display("[TB] FAIL rand_id cycle=%0d got=%0d want=%0d", c, int_id, mId); end
                checks++; if (int_vec !== 32'h100 + 32'(mId) * 4) begin errors++; $display("[TB] FAIL rand_vec cycle=%0d got=%h want=%h", c, int_vec, 32'h100 + 32'(mId) * 4); end
            end
            checks++; if (pending !== mPending) begin errors++; $display("[TB] FAIL rand_pending cycle=%0d got=%b want=%b", c, pending, mPending); end
            checks++; if (in_service !== mInService) begin errors++; $display("[TB] FAIL rand_is cycle=%0d got=%b want=%b", c, in_service, mInService); end
        end
        irq     = '0;
        int_ack = 1'b0;
        int_eoi = 1'b0;
        RST     = 1'b0;
        irq_en  = '1;
        gie     = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_mask_hold();
        test_collision_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout got=running want=finished");
        $fatal(1, "[TB] simulation did not finish in time");
    end

endmodule
